alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Issue stage directly upstream of the arithmetic unit. Accepts one decoded instruction per cycle over a valid/ready handshake and derives the `alu_oper_type` select from the ALU-op class and funct field. Resolves operand A and B from register reads, the immediate, and a writeback forwarding port. Presents registered `a`, `b` and `sel` to the arithmetic unit through a two-entry skid buffer, so backpressure never drops an instruction.

## Interface
Parameters:
- `REG_IDX_W`, 5, register index width.
- `IMM_W`, 16, immediate field width; sign/zero-extended to `$bits(bus_type)`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous; discards all buffered entries.
- `in_valid` / `in_ready`  in / out  1  upstream handshake; transfer when both are high.
- `in_class`  in  `alu_class_type`  ALU-op class: MEM, BRANCH, RTYPE, ANDI, ORI, SLTI, SLTIU.
- `in_funct`  in  6  R-type funct field.
- `in_rs_idx`, `in_rt_idx`, `in_rd_idx`  in  `REG_IDX_W`  source and destination indices.
- `in_rs_data`, `in_rt_data`  in  `bus_type`  register-file read data.
- `in_imm`  in  `IMM_W`  raw immediate.
- `in_use_imm`  in  1  when set, B = extended immediate; when clear, B = rt.
- `fwd_valid`  in  1  writeback forward is valid.
- `fwd_idx`  in  `REG_IDX_W`  writeback destination index.
- `fwd_data`  in  `bus_type`  writeback value.
- `out_valid` / `out_ready`  out / in  1  downstream handshake.
- `out_a`, `out_b`  out  `bus_type`  operands to the arithmetic unit.
- `out_sel`  out  `alu_oper_type`  operation select.
- `out_rd_idx`  out  `REG_IDX_W`  destination index, passed through.
- `out_illegal`  out  1  entry carries an undecodable funct.

## Operation
- Select mapping:
  - MEM→ADD, BRANCH→SUB, ANDI→AND, ORI→OR, SLTI→SLT, SLTIU→SLTU.
  - RTYPE funct: 0x20/0x21→ADD, 0x22/0x23→SUB, 0x24→AND, 0x25→OR, 0x27→NOR, 0x2A→SLT, 0x2B→SLTU.
  - Any other RTYPE funct gives sel=ADD and `out_illegal`=1. The entry still issues.
- Operand resolution for rs (rt identical):
  - index 0 → 0, regardless of read data or forward.
  - else if `fwd_valid` and `fwd_idx` equals the index → `fwd_data`.
  - else → read data.
- Immediate extension: zero-extend for ANDI and ORI; sign-extend for all other classes.
- Operands, select, rd and illegal are all computed and frozen at acceptance. A later forward does not update a buffered entry.
- Buffer FSM states:
  - EMPTY: `out_valid`=0, `in_ready`=1.
  - FULL: `out_valid`=1, `in_ready`=1.
  - SKID: `out_valid`=1, `in_ready`=0. Main and skid registers are both occupied.
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept.
  - FULL stays FULL on accept with drain.
  - FULL→SKID on accept without drain.
  - SKID→FULL on drain; the skid entry moves to main.
- Order is strict FIFO. There is no accept in SKID, since `in_ready`=0.
- `flush` wins over every other event. Next state is EMPTY, and an `in_valid` in the flush cycle is dropped.

## Timing
- Reset values: state EMPTY, `out_valid`=0, `in_ready`=1, `out_a`=`out_b`=0, `out_sel`=ALU_ADD, `out_rd_idx`=0, `out_illegal`=0.
- Reset asserted mid-operation clears all entries immediately, without waiting for a clock edge.
- `in_ready` is a decode of the registered state only. There is no combinational path from `out_ready` to `in_ready`.
- Latency: an entry accepted at edge N is on `out_*` with `out_valid`=1 after edge N. Throughput is one entry per cycle under continuous `out_ready`.
- While `out_valid`=1 and `out_ready`=0, all `out_*` are held stable.
- Forward compare uses same-cycle `fwd_*`: a combinational path into the capture registers, with no extra cycle.

## Structure
- `types` package additions:
  - `alu_class_type` enum.
  - funct constants `FUNCT_ADD` … `FUNCT_SLTU`.
  - `REG_IDX_W` default.
- Existing `bus_type` and `alu_oper_type` are reused unchanged.
- One sub-module, `AluControlModule`: combinational `(in_class, in_funct)` → `(sel, illegal)`.
- Operand mux, extension and the skid FSM stay in this block.

## Test plan
- RTYPE funct 0x2B, rs=3 (0x5), rt=4 (0x9), out_ready=1 → one cycle later out_sel=ALU_SLTU, a=0x5, b=0x9, out_illegal=0.
- ORI imm 0xFFFF; ADDI-class (MEM) imm 0xFFFF → b=0x0000FFFF, then b=0xFFFFFFFF (32-bit build).
- rs_idx=7, fwd_valid=1, fwd_idx=7, fwd_data=0xAA, rs_data=0x11 → a=0xAA. Same stimulus with rs_idx=0 → a=0.
- out_ready=0, three back-to-back in_valid:
  - first two accepted; in_ready drops after the second.
  - third held until a drain.
  - order A, B, C preserved; outputs stable while stalled.
- State SKID, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, the new entry is not issued.
- funct 0x3F RTYPE → out_sel=ALU_ADD, out_illegal=1. Async rst pulse mid-stall → out_valid=0 with no clock edge.

Source files
------------

// File: rtl/alu_issue_stage_pkg.sv
// Shared types for the ALU issue stage: bus and select types, op classes, funct codes.
package alu_issue_stage_pkg;

    localparam int unsigned BUS_W             = 32;
    localparam int unsigned DEFAULT_REG_IDX_W = 5;

    typedef logic [BUS_W-1:0] bus_type;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_NOR  = 3'd4,
        ALU_SLT  = 3'd5,
        ALU_SLTU = 3'd6
    } alu_oper_type;

    typedef enum logic [2:0] {
        CLASS_MEM    = 3'd0,
        CLASS_BRANCH = 3'd1,
        CLASS_RTYPE  = 3'd2,
        CLASS_ANDI   = 3'd3,
        CLASS_ORI    = 3'd4,
        CLASS_SLTI   = 3'd5,
        CLASS_SLTIU  = 3'd6
    } alu_class_type;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull  = 2'd1,
        StSkid  = 2'd2
    } buf_state_type;

endpackage

// File: rtl/alu_issue_stage_alu_control.sv
// Decodes ALU-op class and R-type funct into the arithmetic unit select.
module AluControlModule
    import alu_issue_stage_pkg::*;
(
    input  alu_class_type in_class,
    input  logic [5:0]    in_funct,
    output alu_oper_type  sel,
    output logic          illegal
);

    // Class/funct decode; unknown R-type funct issues as ADD flagged illegal.
    always_comb begin
        sel     = ALU_ADD;
        illegal = 1'b0;
        case (in_class)
            CLASS_MEM:    sel = ALU_ADD;
            CLASS_BRANCH: sel = ALU_SUB;
            CLASS_ANDI:   sel = ALU_AND;
            CLASS_ORI:    sel = ALU_OR;
            CLASS_SLTI:   sel = ALU_SLT;
            CLASS_SLTIU:  sel = ALU_SLTU;
            CLASS_RTYPE: begin
                case (in_funct)
                    FUNCT_ADD, FUNCT_ADDU: sel = ALU_ADD;
                    FUNCT_SUB, FUNCT_SUBU: sel = ALU_SUB;
                    FUNCT_AND:             sel = ALU_AND;
                    FUNCT_OR:              sel = ALU_OR;
                    FUNCT_NOR:             sel = ALU_NOR;
                    FUNCT_SLT:             sel = ALU_SLT;
                    FUNCT_SLTU:            sel = ALU_SLTU;
                    default: begin
                        sel     = ALU_ADD;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: sel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: operand resolution with writeback forwarding, select decode,
// and a two-entry skid buffer in front of the arithmetic unit.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned REG_IDX_W = DEFAULT_REG_IDX_W,
    parameter int unsigned IMM_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  alu_class_type        in_class,
    input  logic [5:0]           in_funct,
    input  logic [REG_IDX_W-1:0] in_rs_idx,
    input  logic [REG_IDX_W-1:0] in_rt_idx,
    input  logic [REG_IDX_W-1:0] in_rd_idx,
    input  bus_type              in_rs_data,
    input  bus_type              in_rt_data,
    input  logic [IMM_W-1:0]     in_imm,
    input  logic                 in_use_imm,
    input  logic                 fwd_valid,
    input  logic [REG_IDX_W-1:0] fwd_idx,
    input  bus_type              fwd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output bus_type              out_a,
    output bus_type              out_b,
    output alu_oper_type         out_sel,
    output logic [REG_IDX_W-1:0] out_rd_idx,
    output logic                 out_illegal
);

    typedef struct packed {
        bus_type              a;
        bus_type              b;
        alu_oper_type         sel;
        logic [REG_IDX_W-1:0] rd;
        logic                 illegal;
    } entry_type;

    buf_state_type state_q, state_d;
    entry_type     main_q, main_d, skid_q, skid_d, new_entry;
    alu_oper_type  dec_sel;
    logic          dec_illegal;
    bus_type       rs_val, rt_val, imm_ext;
    logic          accept, drain;

    AluControlModule u_alu_control (
        .in_class (in_class),
        .in_funct (in_funct),
        .sel      (dec_sel),
        .illegal  (dec_illegal)
    );

    // Resolve operands from register reads, same-cycle forward and immediate.
    always_comb begin
        if (in_rs_idx == '0) begin
            rs_val = '0;
        end else if (fwd_valid && (fwd_idx == in_rs_idx)) begin
            rs_val = fwd_data;
        end else begin
            rs_val = in_rs_data;
        end
        if (in_rt_idx == '0) begin
            rt_val = '0;
        end else if (fwd_valid && (fwd_idx == in_rt_idx)) begin
            rt_val = fwd_data;
        end else begin
            rt_val = in_rt_data;
        end
        if ((in_class == CLASS_ANDI) || (in_class == CLASS_ORI)) begin
            imm_ext = {{(BUS_W-IMM_W){1'b0}}, in_imm};
        end else begin
            imm_ext = {{(BUS_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
        end
        new_entry.a       = rs_val;
        new_entry.b       = in_use_imm ? imm_ext : rt_val;
        new_entry.sel     = dec_sel;
        new_entry.rd      = in_rd_idx;
        new_entry.illegal = dec_illegal;
    end

    // Handshake decode; in_ready depends on registered state only.
    assign in_ready  = (state_q != StSkid);
    assign out_valid = (state_q != StEmpty);
    assign accept    = in_valid && in_ready && !flush;
    assign drain     = out_valid && out_ready;

    // Skid buffer next-state and entry movement; flush overrides everything.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d = StFull;
                        main_d  = new_entry;
                    end
                end
                StFull: begin
                    if (accept && drain) begin
                        main_d = new_entry;
                    end else if (accept) begin
                        state_d = StSkid;
                        skid_d  = new_entry;
                    end else if (drain) begin
                        state_d = StEmpty;
                    end
                end
                StSkid: begin
                    if (drain) begin
                        state_d = StFull;
                        main_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // State and entry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_a       = main_q.a;
    assign out_b       = main_q.b;
    assign out_sel     = main_q.sel;
    assign out_rd_idx  = main_q.rd;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    alu_class_type in_class = CLASS_MEM;
    logic [5:0]    in_funct = '0;
    logic [4:0]    in_rs_idx = '0, in_rt_idx = '0, in_rd_idx = '0;
    bus_type       in_rs_data = '0, in_rt_data = '0;
    logic [15:0]   in_imm = '0;
    logic          in_use_imm = 1'b0;
    logic          fwd_valid = 1'b0;
    logic [4:0]    fwd_idx = '0;
    bus_type       fwd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    bus_type       out_a, out_b;
    alu_oper_type  out_sel;
    logic [4:0]    out_rd_idx;
    logic          out_illegal;

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.REG_IDX_W(5), .IMM_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_class    (in_class),
        .in_funct    (in_funct),
        .in_rs_idx   (in_rs_idx),
        .in_rt_idx   (in_rt_idx),
        .in_rd_idx   (in_rd_idx),
        .in_rs_data  (in_rs_data),
        .in_rt_data  (in_rt_data),
        .in_imm      (in_imm),
        .in_use_imm  (in_use_imm),
        .fwd_valid   (fwd_valid),
        .fwd_idx     (fwd_idx),
        .fwd_data    (fwd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_sel     (out_sel),
        .out_rd_idx  (out_rd_idx),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input alu_class_type c, input logic [5:0] f,
                          input logic [4:0] rs, input bus_type rsd,
                          input logic [4:0] rt, input bus_type rtd,
                          input logic [4:0] rd, input logic [15:0] imm, input logic ui);
        in_valid   = 1'b1;
        in_class   = c;
        in_funct   = f;
        in_rs_idx  = rs;
        in_rs_data = rsd;
        in_rt_idx  = rt;
        in_rt_data = rtd;
        in_rd_idx  = rd;
        in_imm     = imm;
        in_use_imm = ui;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (out_a !== 32'h0) begin errors++; $display("FAIL reset_out_a got %h want 0", out_a); end
        checks++; if (out_b !== 32'h0) begin errors++; $display("FAIL reset_out_b got %h want 0", out_b); end
        checks++; if (out_sel !== ALU_ADD) begin errors++; $display("FAIL reset_out_sel got %0d want %0d", out_sel, ALU_ADD); end
        checks++; if (out_rd_idx !== 5'd0) begin errors++; $display("FAIL reset_out_rd got %0d want 0", out_rd_idx); end
        checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL reset_out_illegal got %0b want 0", out_illegal); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rtype_sltu();
        out_ready = 1'b1;
        set_in(CLASS_RTYPE, 6'h2B, 5'd3, 32'h5, 5'd4, 32'h9, 5'd8, 16'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sltu_valid got %0b want 1", out_valid); end
        checks++; if (out_sel !== ALU_SLTU) begin errors++; $display("FAIL sltu_sel got %0d want %0d", out_sel, ALU_SLTU); end
        checks++; if (out_a !== 32'h5) begin errors++; $display("FAIL sltu_a got %h want 5", out_a); end
        checks++; if (out_b !== 32'h9) begin errors++; $display("FAIL sltu_b got %h want 9", out_b); end
        checks++; if (out_rd_idx !== 5'd8) begin errors++; $display("FAIL sltu_rd got %0d want 8", out_rd_idx); end
        checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL sltu_illegal got %0b want 0", out_illegal); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sltu_drained got %0b want 0", out_valid); end
    endtask

    task automatic test_imm_ext();
        alu_class_type cls[4] = '{CLASS_ORI, CLASS_MEM, CLASS_ANDI, CLASS_SLTI};
        logic [15:0]   imm[4] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000};
        bus_type       exp_b[4] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h00008000, 32'hFFFF8000};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(cls[i], 6'h0, 5'd1, 32'h10, 5'd2, 32'h20, 5'd9, imm[i], 1'b1);
            tick();
            checks++; if (out_b !== exp_b[i]) begin errors++; $display("FAIL imm_ext[%0d] got %h want %h", i, out_b, exp_b[i]); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_forward();
        out_ready = 1'b1;
        fwd_valid = 1'b1; fwd_idx = 5'd7; fwd_data = 32'hAA;
        set_in(CLASS_RTYPE, 6'h20, 5'd7, 32'h11, 5'd2, 32'h22, 5'd1, 16'h0, 1'b0);
        tick();
        checks++; if (out_a !== 32'hAA) begin errors++; $display("FAIL fwd_rs got %h want aa", out_a); end
        checks++; if (out_b !== 32'h22) begin errors++; $display("FAIL fwd_rt_nomatch got %h want 22", out_b); end
        in_rs_idx = 5'd0;
        tick();
        checks++; if (out_a !== 32'h0) begin errors++; $display("FAIL fwd_rs_zero got %h want 0", out_a); end
        in_rs_idx = 5'd3; in_rt_idx = 5'd7;
        tick();
        checks++; if (out_a !== 32'h11) begin errors++; $display("FAIL fwd_rs_read got %h want 11", out_a); end
        checks++; if (out_b !== 32'hAA) begin errors++; $display("FAIL fwd_rt got %h want aa", out_b); end
        fwd_valid = 1'b0; in_rs_idx = 5'd7;
        tick();
        checks++; if (out_a !== 32'h11) begin errors++; $display("FAIL fwd_invalid got %h want 11", out_a); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        set_in(CLASS_RTYPE, 6'h20, 5'd1, 32'hA, 5'd2, 32'h0, 5'd1, 16'h0, 1'b0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %0b want 1", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %0b want 1", in_ready); end
        in_rs_data = 32'hB; in_rd_idx = 5'd2;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready2 got %0b want 0", in_ready); end
        in_rs_data = 32'hC; in_rd_idx = 5'd3;
        // Forward to rs of a buffered entry must not disturb it.
        fwd_valid = 1'b1; fwd_idx = 5'd1; fwd_data = 32'hDEAD;
        tick();
        fwd_valid = 1'b0;
        checks++; if (out_a !== 32'hA) begin errors++; $display("FAIL b2b_stall_a got %h want a", out_a); end
        checks++; if (out_rd_idx !== 5'd1) begin errors++; $display("FAIL b2b_stall_rd got %0d want 1", out_rd_idx); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_held got %0b want 0", in_ready); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_a !== 32'hB) begin errors++; $display("FAIL b2b_second got %h want b", out_a); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_reopen got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_a !== 32'hC) begin errors++; $display("FAIL b2b_third got %h want c", out_a); end
        checks++; if (out_rd_idx !== 5'd3) begin errors++; $display("FAIL b2b_third_rd got %0d want 3", out_rd_idx); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_in(CLASS_MEM, 6'h0, 5'd1, 32'h1, 5'd0, 32'h0, 5'd4, 16'h0, 1'b0);
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_skid got %0b want 0", in_ready); end
        flush = 1'b1;
        in_rd_idx = 5'd5;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b want 1", in_ready); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got %0b want 0", out_valid); end
    endtask

    task automatic test_decode();
        alu_class_type cls[8] = '{CLASS_RTYPE, CLASS_RTYPE, CLASS_RTYPE, CLASS_RTYPE,
                                  CLASS_RTYPE, CLASS_RTYPE, CLASS_BRANCH, CLASS_SLTIU};
        logic [5:0]    fn[8] = '{6'h20, 6'h23, 6'h24, 6'h27, 6'h2A, 6'h3F, 6'h00, 6'h3F};
        alu_oper_type  es[8] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_NOR,
                                 ALU_SLT, ALU_ADD, ALU_SUB, ALU_SLTU};
        logic          ei[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(cls[i], fn[i], 5'd1, 32'h1, 5'd2, 32'h2, 5'd6, 16'h0, 1'b0);
            tick();
            checks++; if (out_sel !== es[i]) begin errors++; $display("FAIL decode_sel[%0d] got %0d want %0d", i, out_sel, es[i]); end
            checks++; if (out_illegal !== ei[i]) begin errors++; $display("FAIL decode_illegal[%0d] got %0b want %0b", i, out_illegal, ei[i]); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        set_in(CLASS_MEM, 6'h0, 5'd1, 32'h77, 5'd0, 32'h0, 5'd2, 16'h0, 1'b0);
        tick();
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got %0b want 1", out_valid); end
        #1 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %0b want 1", in_ready); end
        checks++; if (out_a !== 32'h0) begin errors++; $display("FAIL arst_a got %h want 0", out_a); end
        #1 rst = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_after got %0b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_rtype_sltu();
        test_imm_ext();
        test_forward();
        test_back_to_back();
        test_flush();
        test_decode();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
